rv32i_regfile_sequencer: RTL and testbench

- Initiator side of the GPREGS register-file interface: accepts one RV32I instruction word at a time, decodes rs1/rs2/rd, and drives the register file read ports.
- Presents the captured operands to the execute stage, then collects the execute result and drives the register file write port.
- Sits between fetch and execute inside RV32I_CORE; the core's only user of the GPREGS ports.

---
 rtl/rv32i_regfile_sequencer.sv | 156 +++++++++++++++
 tb/tb_rv32i_regfile_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile_sequencer.sv
// RV32I register-file sequencer: accepts one instruction at a time, reads
// rs1/rs2 from GPREGS, hands operands to execute, then writes the result
// back to rd. Strictly one instruction in flight.
module rv32i_regfile_sequencer #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      cpurst,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [31:0]               inst,
    output logic [REG_ADDR_WIDTH-1:0] read_reg_0,
    output logic [REG_ADDR_WIDTH-1:0] read_reg_1,
    input  logic [REG_DATA_WIDTH-1:0] dout_reg_0,
    input  logic [REG_DATA_WIDTH-1:0] dout_reg_1,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [31:0]               op_inst,
    output logic [REG_DATA_WIDTH-1:0] op_rs1_data,
    output logic [REG_DATA_WIDTH-1:0] op_rs2_data,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [REG_DATA_WIDTH-1:0] wb_data,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [REG_DATA_WIDTH-1:0] din,
    output logic                      din_enable,
    output logic [CNT_WIDTH-1:0]      retire_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_WB = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] read_reg_0_q, read_reg_0_d;
    logic [REG_ADDR_WIDTH-1:0] read_reg_1_q, read_reg_1_d;
    logic [31:0]               op_inst_q, op_inst_d;
    logic [REG_DATA_WIDTH-1:0] op_rs1_q, op_rs1_d;
    logic [REG_DATA_WIDTH-1:0] op_rs2_q, op_rs2_d;
    logic                      writes_q, writes_d;
    logic [REG_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
    logic [REG_DATA_WIDTH-1:0] din_q, din_d;
    logic [CNT_WIDTH-1:0]      retire_q, retire_d;

    // Instruction classes that produce a register result; rd == x0 never writes.
    function automatic logic inst_writes(input logic [31:0] w);
        logic wr;
        case (w[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0010011, 7'b0110011: wr = (w[11:7] != 5'd0);
            default:                            wr = 1'b0;
        endcase
        return wr;
    endfunction

    // Next-state and datapath capture for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        read_reg_0_d = read_reg_0_q;
        read_reg_1_d = read_reg_1_q;
        op_inst_d    = op_inst_q;
        op_rs1_d     = op_rs1_q;
        op_rs2_d     = op_rs2_q;
        writes_d     = writes_q;
        write_reg_d  = write_reg_q;
        din_d        = din_q;
        retire_d     = retire_q;
        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    op_inst_d    = inst;
                    read_reg_0_d = REG_ADDR_WIDTH'(inst[19:15]);
                    read_reg_1_d = REG_ADDR_WIDTH'(inst[24:20]);
                    writes_d     = inst_writes(inst);
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                op_rs1_d = (read_reg_0_q == '0) ? '0 : dout_reg_0;
                op_rs2_d = (read_reg_1_q == '0) ? '0 : dout_reg_1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) begin
                    if (writes_q) begin
                        state_d = S_WAIT_WB;
                    end else begin
                        state_d  = S_IDLE;
                        retire_d = retire_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_WAIT_WB: begin
                if (wb_valid) begin
                    din_d       = wb_data;
                    write_reg_d = REG_ADDR_WIDTH'(op_inst_q[11:7]);
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d  = S_IDLE;
                retire_d = retire_q + CNT_WIDTH'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight instruction immediately.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q      <= S_IDLE;
            read_reg_0_q <= '0;
            read_reg_1_q <= '0;
            op_inst_q    <= '0;
            op_rs1_q     <= '0;
            op_rs2_q     <= '0;
            writes_q     <= 1'b0;
            write_reg_q  <= '0;
            din_q        <= '0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            read_reg_0_q <= read_reg_0_d;
            read_reg_1_q <= read_reg_1_d;
            op_inst_q    <= op_inst_d;
            op_rs1_q     <= op_rs1_d;
            op_rs2_q     <= op_rs2_d;
            writes_q     <= writes_d;
            write_reg_q  <= write_reg_d;
            din_q        <= din_d;
            retire_q     <= retire_d;
        end
    end

    // Handshake strobes decode directly from state; inst_ready is gated by reset.
    always_comb begin
        inst_ready = (state_q == S_IDLE) && !cpurst;
        op_valid   = (state_q == S_ISSUE);
        wb_ready   = (state_q == S_WAIT_WB);
        din_enable = (state_q == S_WRITE);
    end

    assign read_reg_0   = read_reg_0_q;
    assign read_reg_1   = read_reg_1_q;
    assign op_inst      = op_inst_q;
    assign op_rs1_data  = op_rs1_q;
    assign op_rs2_data  = op_rs2_q;
    assign write_reg    = write_reg_q;
    assign din          = din_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_rv32i_regfile_sequencer.sv
// Directed + randomized bench for rv32i_regfile_sequencer with a GPREGS
// stand-in and an architectural reference model of the register file.
module tb_rv32i_regfile_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          cpurst;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] read_reg_0, read_reg_1;
    logic [DW-1:0] dout_reg_0, dout_reg_1;
    logic          op_valid;
    logic          op_ready;
    logic [31:0]   op_inst;
    logic [DW-1:0] op_rs1_data, op_rs2_data;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] din;
    logic          din_enable;
    logic [CW-1:0] retire_count;

    rv32i_regfile_sequencer #(
        .REG_DATA_WIDTH(DW),
        .REG_ADDR_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .cpurst(cpurst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .dout_reg_0(dout_reg_0), .dout_reg_1(dout_reg_1),
        .op_valid(op_valid), .op_ready(op_ready), .op_inst(op_inst),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .write_reg(write_reg), .din(din), .din_enable(din_enable),
        .retire_count(retire_count)
    );

    // GPREGS stand-in: x0 deliberately reads as all ones to expose missing forcing.
    logic [31:0] rf  [32];
    logic [31:0] mdl [32];

    assign dout_reg_0 = rf[read_reg_0];
    assign dout_reg_1 = rf[read_reg_1];

    always @(posedge clk) begin
        if (din_enable && write_reg != 5'd0) rf[write_reg] <= din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int passed = 0;
    int total  = 0;
    int mcnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_writes(input logic [31:0] w);
        logic [6:0] opc;
        opc = w[6:0];
        if (w[11:7] == 5'd0) return 1'b0;
        return (opc == 7'h37) || (opc == 7'h17) || (opc == 7'h6F) || (opc == 7'h67) ||
               (opc == 7'h03) || (opc == 7'h13) || (opc == 7'h33);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23, 7'h7F};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    // One complete instruction: issue, hold-off on op_ready, optional writeback.
    task automatic run_inst(input logic [31:0] w, input int rdy_dly, input int wb_dly,
                            input logic [31:0] res);
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] ea, eb;
        logic        wr;
        rs1 = w[19:15];
        rs2 = w[24:20];
        rd  = w[11:7];
        ea  = (rs1 == 5'd0) ? 32'd0 : mdl[rs1];
        eb  = (rs2 == 5'd0) ? 32'd0 : mdl[rs2];
        wr  = model_writes(w);

        chk("inst_ready_idle", {31'd0, inst_ready}, 32'd1);
        inst = w;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        inst = $urandom;
        chk("read_reg_0", {27'd0, read_reg_0}, {27'd0, rs1});
        chk("read_reg_1", {27'd0, read_reg_1}, {27'd0, rs2});
        chk("op_valid_read", {31'd0, op_valid}, 32'd0);
        tick();
        chk("op_valid_issue", {31'd0, op_valid}, 32'd1);
        chk("op_inst", op_inst, w);
        chk("op_rs1_data", op_rs1_data, ea);
        chk("op_rs2_data", op_rs2_data, eb);
        for (int i = 0; i < rdy_dly; i++) begin
            inst_valid = 1'($urandom);
            wb_valid   = 1'($urandom);
            wb_data    = $urandom;
            tick();
            chk("op_valid_hold", {31'd0, op_valid}, 32'd1);
            chk("op_inst_hold", op_inst, w);
            chk("op_rs1_hold", op_rs1_data, ea);
            chk("op_rs2_hold", op_rs2_data, eb);
            chk("inst_ready_busy", {31'd0, inst_ready}, 32'd0);
            chk("din_en_issue", {31'd0, din_enable}, 32'd0);
        end
        inst_valid = 1'b0;
        wb_valid   = 1'b0;
        op_ready   = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("op_valid_after", {31'd0, op_valid}, 32'd0);
        if (wr) begin
            chk("wb_ready", {31'd0, wb_ready}, 32'd1);
            for (int i = 0; i < wb_dly; i++) begin
                inst_valid = 1'($urandom);
                tick();
                chk("wb_ready_hold", {31'd0, wb_ready}, 32'd1);
                chk("din_en_wait", {31'd0, din_enable}, 32'd0);
            end
            inst_valid = 1'b0;
            wb_valid   = 1'b1;
            wb_data    = res;
            tick();
            wb_valid = 1'b0;
            wb_data  = $urandom;
            chk("din_enable", {31'd0, din_enable}, 32'd1);
            chk("write_reg", {27'd0, write_reg}, {27'd0, rd});
            chk("din", din, res);
            mdl[rd] = res;
            mcnt++;
            tick();
            chk("din_en_once", {31'd0, din_enable}, 32'd0);
            chk("inst_ready_back", {31'd0, inst_ready}, 32'd1);
        end else begin
            chk("wb_ready_skip", {31'd0, wb_ready}, 32'd0);
            chk("inst_ready_nowr", {31'd0, inst_ready}, 32'd1);
            mcnt++;
            wb_valid = 1'b1;
            wb_data  = res;
            tick();
            wb_valid = 1'b0;
            chk("din_en_nowr", {31'd0, din_enable}, 32'd0);
        end
        chk("retire_count", {28'd0, retire_count}, 32'(mcnt % 16));
    endtask

    initial begin
        cpurst = 1'b1;
        inst_valid = 1'b0;
        inst = '0;
        op_ready = 1'b0;
        wb_valid = 1'b0;
        wb_data = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]  = $urandom;
            mdl[i] = rf[i];
        end
        rf[0] = 32'hFFFF_FFFF;
        mdl[0] = 32'd0;
        rf[1] = 32'h10; mdl[1] = 32'h10;
        rf[2] = 32'h20; mdl[2] = 32'h20;

        #1;
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_retire", {28'd0, retire_count}, 32'd0);
        chk("rst_din_en", {31'd0, din_enable}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpurst = 1'b0;
        tick();

        // ADDI x5,x0,7
        run_inst(32'h0070_0293, 0, 1, 32'd7);
        // ADD x3,x1,x2
        run_inst(32'h0020_81B3, 1, 0, 32'h30);
        // ADDI x0,x0,5: no write, x0 read forced to zero
        run_inst(32'h0050_0013, 2, 0, 32'd5);
        // BEQ with op_ready held off three cycles
        run_inst(32'h0020_8463, 3, 0, 32'd0);

        // Reset while waiting for the result of ADDI x6,x1,1
        chk("rw_inst_ready", {31'd0, inst_ready}, 32'd1);
        inst = 32'h0010_8313;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("rw_wb_ready", {31'd0, wb_ready}, 32'd1);
        #2;
        cpurst = 1'b1;
        wb_valid = 1'b1;
        wb_data = 32'hDEAD_BEEF;
        #1;
        chk("rw_din_en", {31'd0, din_enable}, 32'd0);
        chk("rw_wb_ready_0", {31'd0, wb_ready}, 32'd0);
        chk("rw_inst_ready_0", {31'd0, inst_ready}, 32'd0);
        chk("rw_read_reg_0", {27'd0, read_reg_0}, 32'd0);
        chk("rw_op_inst", op_inst, 32'd0);
        chk("rw_op_rs1", op_rs1_data, 32'd0);
        chk("rw_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rw_din", din, 32'd0);
        chk("rw_retire", {28'd0, retire_count}, 32'd0);
        tick();
        chk("rw_din_en_hold", {31'd0, din_enable}, 32'd0);
        wb_valid = 1'b0;
        @(negedge clk);
        cpurst = 1'b0;
        mcnt = 0;
        tick();
        chk("rw_inst_ready_rel", {31'd0, inst_ready}, 32'd1);
        chk("rw_din_en_rel", {31'd0, din_enable}, 32'd0);

        // Seventeen retirements wrap the 4-bit counter to 1
        for (int n = 0; n < 17; n++) begin
            run_inst(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end
        chk("wrap_17", {28'd0, retire_count}, 32'd1);

        for (int n = 0; n < 30; n++) begin
            run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        for (int i = 1; i < 32; i++) begin
            chk("regfile_final", rf[i], mdl[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
